// File: rtl/oam_dma.sv
// OAM DMA engine: halts the CPU and copies one 256-byte CPU page
// into the PPU sprite OAM through the OAM data port.
module oam_dma #(
   parameter logic [15:0] DMA_REG      = 16'h4014,
   parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_wr_i,
   input  logic        cpu_rd_i,
   output logic        halt_o,
   output logic        master_o,
   output logic [15:0] addr_o,
   output logic        rw_o,
   input  logic [7:0]  data_i,
   output logic [7:0]  data_o,
   output logic        oam_wr_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } state_t;

   state_t      state;
   state_t      nxt;
   logic        put;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  dbuf;
   logic [7:0]  nxt_page;
   logic [7:0]  nxt_idx;
   logic [7:0]  nxt_buf;

   always_comb begin
      nxt      = state;
      nxt_page = page;
      nxt_idx  = idx;
      nxt_buf  = dbuf;
      unique case (state)
         IDLE: begin
            if (cpu_wr_i && cpu_addr_i == DMA_REG) begin
               nxt      = HALT;
               nxt_page = cpu_data_i;
               nxt_idx  = 8'h00;
            end
         end
         // put=1 now means the next ce is a get, so the read can start
         HALT: begin
            if (cpu_rd_i)
               nxt = put ? READ : ALIGN;
         end
         ALIGN: nxt = READ;
         READ: begin
            nxt_buf = data_i;
            nxt     = WRITE;
         end
         WRITE: begin
            nxt_idx = idx + 8'h01;
            nxt     = (idx == 8'hFF) ? IDLE : READ;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         put      <= 1'b0;
         page     <= 8'h00;
         idx      <= 8'h00;
         dbuf     <= 8'h00;
         halt_o   <= 1'b0;
         master_o <= 1'b0;
         rw_o     <= 1'b1;
         addr_o   <= 16'h0000;
      end else if (ce) begin
         put      <= ~put;
         state    <= nxt;
         page     <= nxt_page;
         idx      <= nxt_idx;
         dbuf     <= nxt_buf;
         halt_o   <= (nxt != IDLE);
         master_o <= (nxt == ALIGN) || (nxt == READ) || (nxt == WRITE);
         rw_o     <= (nxt != WRITE);
         if (nxt == WRITE)
            addr_o <= OAMDATA_ADDR;
         else if (nxt == ALIGN || nxt == READ)
            addr_o <= {nxt_page, nxt_idx};
         else
            addr_o <= 16'h0000;
      end
   end

   assign data_o   = dbuf;
   assign busy_o   = (state != IDLE);
   assign oam_wr_o = ce && (state == WRITE);
   assign done_o   = ce && !rst && (state == WRITE) && (idx == 8'hFF);

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table of transfers plus reset/retrigger corners,
// with a byte scoreboard filled at trigger time and drained on OAM writes.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_data_i;
   logic        cpu_wr_i;
   logic        cpu_rd_i;
   logic        halt_o;
   logic        master_o;
   logic [15:0] addr_o;
   logic        rw_o;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        oam_wr_o;
   logic        busy_o;
   logic        done_o;

   oam_dma dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .cpu_addr_i (cpu_addr_i),
      .cpu_data_i (cpu_data_i),
      .cpu_wr_i   (cpu_wr_i),
      .cpu_rd_i   (cpu_rd_i),
      .halt_o     (halt_o),
      .master_o   (master_o),
      .addr_o     (addr_o),
      .rw_o       (rw_o),
      .data_i     (data_i),
      .data_o     (data_o),
      .oam_wr_o   (oam_wr_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      logic [7:0] m;
      m = a[7:0] * 8'd7;
      return m ^ a[15:8] ^ 8'h3C;
   endfunction

   assign data_i = mem_byte(addr_o);

   typedef struct {
      logic [7:0] page;
      bit         trig_put;
      int         hold;
      int         div;
      bit         retrig;
      int         rst_at;
      int         align;
      int         total;
   } vec_t;

   vec_t tbl [7];

   int          checks = 0;
   int          errors = 0;
   bit          tb_put;
   int          ce_count = 0;
   int          div = 1;
   logic [7:0]  exp_page;
   int          wcount, reads, aligns, done_cnt, done_ce;
   logic [15:0] last_rd;
   logic [7:0]  q [$];
   bit          prev_ce = 1'b1;
   logic [27:0] snap;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sample();
      logic [7:0] e;
      if (ce) begin
         if (master_o && rw_o) begin
            if (tb_put) aligns++;
            else begin
               reads++;
               last_rd = addr_o;
            end
         end
         if (oam_wr_o) begin
            chk("wr_put", 32'(tb_put), 1);
            chk("wr_addr", 32'(addr_o), 32'h2004);
            chk("wr_rw", 32'(rw_o), 0);
            chk("wr_master", 32'(master_o), 1);
            chk("wr_src", 32'(last_rd), 32'({exp_page, wcount[7:0]}));
            chk("wr_q", 32'(q.size() != 0), 1);
            e = 8'h00;
            if (q.size() != 0) e = q.pop_front();
            chk("wr_data", 32'(data_o), 32'(e));
            wcount++;
         end
         if (done_o) begin
            done_cnt++;
            done_ce = ce_count;
         end
      end else begin
         chk("noce_wr", 32'(oam_wr_o), 0);
         chk("noce_done", 32'(done_o), 0);
         if (!prev_ce)
            chk("noce_hold",
                32'({halt_o, master_o, rw_o, addr_o, data_o, busy_o}),
                32'(snap));
      end
      snap    = {halt_o, master_o, rw_o, addr_o, data_o, busy_o};
      prev_ce = ce;
   endtask

   task automatic clk1(input logic c);
      ce = c;
      #1;
      sample();
      @(posedge clk);
      #1;
      if (c) begin
         tb_put = ~tb_put;
         ce_count++;
      end
   endtask

   task automatic step();
      clk1(1'b1);
      for (int i = 1; i < div; i++) clk1(1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ce  = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      tb_put  = 1'b0;
      prev_ce = 1'b1;
   endtask

   initial begin
      int trig;
      bit aborted;
      bit did_retrig;

      tbl[0] = '{8'h02, 1'b0, 0, 1, 1'b0, 0, 0, 513};
      tbl[1] = '{8'h02, 1'b1, 0, 1, 1'b0, 0, 1, 514};
      tbl[2] = '{8'h02, 1'b0, 2, 1, 1'b0, 0, 0, 515};
      tbl[3] = '{8'h02, 1'b0, 0, 1, 1'b1, 0, 0, 513};
      tbl[4] = '{8'h02, 1'b0, 0, 1, 1'b0, 100, 0, 0};
      tbl[5] = '{8'h02, 1'b1, 0, 1, 1'b0, 0, 1, 514};
      tbl[6] = '{8'hFF, 1'b0, 0, 3, 1'b0, 0, 0, 513};

      rst        = 1'b1;
      ce         = 1'b0;
      cpu_addr_i = 16'h0000;
      cpu_data_i = 8'h00;
      cpu_wr_i   = 1'b0;
      cpu_rd_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      tb_put = 1'b0;

      chk("rst_halt", 32'(halt_o), 0);
      chk("rst_master", 32'(master_o), 0);
      chk("rst_addr", 32'(addr_o), 0);
      chk("rst_rw", 32'(rw_o), 1);
      chk("rst_data", 32'(data_o), 0);
      chk("rst_busy", 32'(busy_o), 0);

      // trigger coincident with rst: rst must win
      cpu_addr_i = 16'h4014;
      cpu_data_i = 8'h33;
      cpu_wr_i   = 1'b1;
      do_reset();
      cpu_wr_i = 1'b0;
      cpu_rd_i = 1'b1;
      chk("rst_trig_busy", 32'(busy_o), 0);
      chk("rst_trig_halt", 32'(halt_o), 0);

      foreach (tbl[v]) begin
         div        = tbl[v].div;
         exp_page   = tbl[v].page;
         wcount     = 0;
         reads      = 0;
         aligns     = 0;
         done_cnt   = 0;
         done_ce    = 0;
         aborted    = 1'b0;
         did_retrig = 1'b0;
         q.delete();
         cpu_wr_i   = 1'b0;
         cpu_rd_i   = 1'b1;
         cpu_addr_i = 16'h8000;
         if (tb_put != tbl[v].trig_put) step();

         for (int k = 0; k < 256; k++)
            q.push_back(mem_byte({tbl[v].page, 8'(k)}));
         cpu_addr_i = 16'h4014;
         cpu_data_i = tbl[v].page;
         cpu_wr_i   = 1'b1;
         cpu_rd_i   = 1'b0;
         trig       = ce_count;
         step();
         chk("trig_busy", 32'(busy_o), 1);
         chk("trig_halt", 32'(halt_o), 1);
         chk("trig_master", 32'(master_o), 0);

         for (int h = 0; h < tbl[v].hold; h++) begin
            cpu_addr_i = 16'h0300;
            step();
            chk("hold_halt", 32'(halt_o), 1);
            chk("hold_master", 32'(master_o), 0);
         end

         cpu_wr_i   = 1'b0;
         cpu_rd_i   = 1'b1;
         cpu_addr_i = 16'h8001;
         step();

         for (int n = 0; n < 600 && done_cnt == 0; n++) begin
            if (tbl[v].retrig && wcount == 50 && !did_retrig) begin
               cpu_addr_i = 16'h4014;
               cpu_data_i = 8'h05;
               cpu_wr_i   = 1'b1;
               cpu_rd_i   = 1'b0;
               step();
               cpu_wr_i   = 1'b0;
               cpu_rd_i   = 1'b1;
               did_retrig = 1'b1;
            end else if (tbl[v].rst_at != 0 &&
                         wcount == tbl[v].rst_at) begin
               do_reset();
               chk("mid_rst_halt", 32'(halt_o), 0);
               chk("mid_rst_master", 32'(master_o), 0);
               chk("mid_rst_busy", 32'(busy_o), 0);
               chk("mid_rst_done", 32'(done_cnt), 0);
               aborted = 1'b1;
               break;
            end else begin
               chk("run_halt", 32'(halt_o), 1);
               step();
            end
         end

         if (!aborted) begin
            chk("done_count", 32'(done_cnt), 1);
            chk("write_count", 32'(wcount), 256);
            chk("read_count", 32'(reads), 256);
            chk("align_count", 32'(aligns), 32'(tbl[v].align));
            chk("total_ce", 32'(done_ce - trig), 32'(tbl[v].total));
            chk("q_empty", 32'(q.size()), 0);
            repeat (4) step();
            chk("post_busy", 32'(busy_o), 0);
            chk("post_halt", 32'(halt_o), 0);
            chk("post_master", 32'(master_o), 0);
            chk("post_done", 32'(done_cnt), 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
